octa_channel_scanner: RTL and testbench

Sequencer that sits beside the eight-channel ADC selector. It drives the selector's 3-bit channel select and consumes the selected sample word. It sweeps round-robin over a mask of enabled channels. On each channel switch it discards settling samples, then forwards a fixed number of samples per channel. Output is a single-register AXI-Stream tagged with channel number and an end-of-sweep marker.

---
 rtl/octa_scan_pkg.sv | 10 +
 rtl/octa_channel_scanner_if.sv | 20 ++
 rtl/octa_next_channel.sv | 24 ++
 rtl/octa_channel_scanner.sv | 121 ++++++++++++
 tb/tb_octa_channel_scanner.sv | 331 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/octa_scan_pkg.sv
// octa_scan_pkg: shared constants, scanner state type and lowest-channel helper
package octa_scan_pkg;
  localparam int NUM_CHAN = 8;
  localparam int CHAN_BITS = 3;
  typedef enum logic [1:0] {S_IDLE, S_SKIP, S_DWELL} state_t;
  function automatic logic [CHAN_BITS-1:0] lowest_set(input logic [NUM_CHAN-1:0] m);
    lowest_set = '0;
    for (int i = NUM_CHAN - 1; i >= 0; i--) if (m[i]) lowest_set = CHAN_BITS'(i);
  endfunction
endpackage

// File: rtl/octa_channel_scanner_if.sv
// octa_channel_scanner_if: selector control/data and output AXI-Stream of the scanner
interface octa_channel_scanner_if #(parameter int DATA_WIDTH = 32);
  import octa_scan_pkg::*;
  logic [CHAN_BITS-1:0] sel_cfg;
  logic [DATA_WIDTH-1:0] sel_data;
  logic s_axis_tvalid;
  logic [DATA_WIDTH-1:0] m_axis_tdata;
  logic [CHAN_BITS-1:0] m_axis_tuser;
  logic m_axis_tlast;
  logic m_axis_tvalid;
  logic m_axis_tready;
  modport master(
    output sel_cfg, m_axis_tdata, m_axis_tuser, m_axis_tlast, m_axis_tvalid,
    input sel_data, s_axis_tvalid, m_axis_tready
  );
  modport slave(
    input sel_cfg, m_axis_tdata, m_axis_tuser, m_axis_tlast, m_axis_tvalid,
    output sel_data, s_axis_tvalid, m_axis_tready
  );
endinterface

// File: rtl/octa_next_channel.sv
// octa_next_channel: next enabled channel above the current one, wrap flag and highest enabled channel
module octa_next_channel
  import octa_scan_pkg::*;
(
  input  logic [NUM_CHAN-1:0]  mask_i,
  input  logic [CHAN_BITS-1:0] cur_i,
  output logic [CHAN_BITS-1:0] next_o,
  output logic                 wrap_o,
  output logic [CHAN_BITS-1:0] high_o
);
  // descending scan leaves the lowest qualifying bit; a miss wraps to the lowest set bit
  always_comb begin
    next_o = lowest_set(mask_i);
    wrap_o = 1'b1;
    high_o = '0;
    for (int i = NUM_CHAN - 1; i >= 0; i--) begin
      if (mask_i[i] && i > int'(cur_i)) begin
        next_o = CHAN_BITS'(i);
        wrap_o = 1'b0;
      end
    end
    for (int i = 0; i < NUM_CHAN; i++) if (mask_i[i]) high_o = CHAN_BITS'(i);
  end
endmodule

// File: rtl/octa_channel_scanner.sv
// octa_channel_scanner: round-robin ADC channel sequencer with settle-skip, dwell and tagged AXI-Stream output
module octa_channel_scanner
  import octa_scan_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int CNTR_WIDTH = 16,
  parameter int SKIP = 2
) (
  input  logic                  aclk,
  input  logic                  areset,
  input  logic                  cfg_enable,
  input  logic [NUM_CHAN-1:0]   cfg_mask,
  input  logic [CNTR_WIDTH-1:0] cfg_dwell,
  input  logic                  ovf_clear,
  octa_channel_scanner_if.master axis,
  output logic                  overflow,
  output logic                  busy
);
  state_t state_q, state_d;
  logic [CHAN_BITS-1:0] sel_q, sel_d, nxt, high;
  logic [NUM_CHAN-1:0] mask_q, mask_d;
  logic [CNTR_WIDTH-1:0] dwell_q, dwell_d, cnt_q, cnt_d, eff_m1;
  logic [DATA_WIDTH-1:0] tdata_q, tdata_d;
  logic [CHAN_BITS-1:0] tuser_q, tuser_d;
  logic tlast_q, tlast_d, tvalid_q, tvalid_d, ovf_q, ovf_d;
  logic wrap, last, fwd, load, drop;

  octa_next_channel u_next (
    .mask_i(mask_q),
    .cur_i (sel_q),
    .next_o(nxt),
    .wrap_o(wrap),
    .high_o(high)
  );

  assign eff_m1 = (dwell_q == '0) ? '0 : dwell_q - 1'b1;
  assign last = cnt_q == eff_m1;

  // sweep sequencing: latch config on start and wrap, count skip/dwell strobes, pick next channel
  always_comb begin
    state_d = state_q;
    sel_d = sel_q;
    mask_d = mask_q;
    dwell_d = dwell_q;
    cnt_d = cnt_q;
    fwd = 1'b0;
    if (!cfg_enable) state_d = S_IDLE;
    else if (state_q == S_IDLE) begin
      if (cfg_mask != '0) begin
        mask_d = cfg_mask;
        dwell_d = cfg_dwell;
        sel_d = lowest_set(cfg_mask);
        cnt_d = '0;
        state_d = (SKIP > 0 && sel_d != sel_q) ? S_SKIP : S_DWELL;
      end
    end else if (axis.s_axis_tvalid) begin
      cnt_d = cnt_q + 1'b1;
      if (state_q == S_SKIP) begin
        if (cnt_q == CNTR_WIDTH'(SKIP - 1)) begin
          cnt_d = '0;
          state_d = S_DWELL;
        end
      end else begin
        fwd = 1'b1;
        if (last) begin
          cnt_d = '0;
          if (wrap) begin
            mask_d = cfg_mask;
            dwell_d = cfg_dwell;
          end
          sel_d = !wrap ? nxt : (cfg_mask == '0) ? sel_q : lowest_set(cfg_mask);
          state_d = (wrap && cfg_mask == '0) ? S_IDLE :
                    (SKIP > 0 && sel_d != sel_q) ? S_SKIP : S_DWELL;
        end
      end
    end
  end

  assign load = fwd && (!tvalid_q || axis.m_axis_tready);
  assign drop = fwd && tvalid_q && !axis.m_axis_tready;
  assign tvalid_d = load || (tvalid_q && !axis.m_axis_tready);
  assign tdata_d = load ? axis.sel_data : tdata_q;
  assign tuser_d = load ? sel_q : tuser_q;
  assign tlast_d = load ? (last && sel_q == high) : tlast_q;
  assign ovf_d = drop || (ovf_q && !ovf_clear);

  // state, configuration and single output register with asynchronous reset
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state_q <= S_IDLE;
      sel_q <= '0;
      mask_q <= '0;
      dwell_q <= '0;
      cnt_q <= '0;
      tdata_q <= '0;
      tuser_q <= '0;
      tlast_q <= 1'b0;
      tvalid_q <= 1'b0;
      ovf_q <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q <= sel_d;
      mask_q <= mask_d;
      dwell_q <= dwell_d;
      cnt_q <= cnt_d;
      tdata_q <= tdata_d;
      tuser_q <= tuser_d;
      tlast_q <= tlast_d;
      tvalid_q <= tvalid_d;
      ovf_q <= ovf_d;
    end
  end

  assign axis.sel_cfg = sel_q;
  assign axis.m_axis_tdata = tdata_q;
  assign axis.m_axis_tuser = tuser_q;
  assign axis.m_axis_tlast = tlast_q;
  assign axis.m_axis_tvalid = tvalid_q;
  assign overflow = ovf_q;
  assign busy = state_q != S_IDLE;
endmodule

// File: tb/tb_octa_channel_scanner.sv
// tb_octa_channel_scanner: randomized scenarios checked cycle by cycle against a sweep-level reference model
module tb_octa_channel_scanner;
  import octa_scan_pkg::*;
  localparam int DW = 32;
  localparam int CW = 16;
  localparam int SK = 2;

  logic aclk = 1'b0;
  logic areset, cfg_enable, ovf_clear, overflow, busy;
  logic [7:0] cfg_mask;
  logic [CW-1:0] cfg_dwell;
  int errors = 0;
  int checks = 0;

  octa_channel_scanner_if #(.DATA_WIDTH(DW)) bus ();

  octa_channel_scanner #(.DATA_WIDTH(DW), .CNTR_WIDTH(CW), .SKIP(SK)) dut (
    .aclk(aclk),
    .areset(areset),
    .cfg_enable(cfg_enable),
    .cfg_mask(cfg_mask),
    .cfg_dwell(cfg_dwell),
    .ovf_clear(ovf_clear),
    .axis(bus),
    .overflow(overflow),
    .busy(busy)
  );

  always #5 aclk = ~aclk;

  // reference model: a visit is "skip k strobes, then forward d strobes", channels walked by bit search
  bit m_busy, m_skip, m_ovf, o_v, o_l;
  int m_left;
  logic [2:0] m_ch, o_u;
  logic [7:0] m_mask;
  logic [CW-1:0] m_dwell;
  logic [DW-1:0] o_d;

  function automatic int lowest(input logic [7:0] m);
    for (int i = 0; i < 8; i++) if (m[i]) return i;
    return 0;
  endfunction

  function automatic int highest(input logic [7:0] m);
    for (int i = 7; i >= 0; i--) if (m[i]) return i;
    return 0;
  endfunction

  function automatic int next_above(input logic [7:0] m, input int c);
    for (int i = c + 1; i < 8; i++) if (m[i]) return i;
    return -1;
  endfunction

  function automatic int eff(input logic [CW-1:0] d);
    return (d == 0) ? 1 : int'(d);
  endfunction

  task automatic mreset();
    m_busy = 0; m_skip = 0; m_ovf = 0; o_v = 0; o_l = 0;
    m_left = 0; m_ch = 0; o_u = 0; m_mask = 0; m_dwell = 0; o_d = 0;
  endtask

  task automatic visit(input int n);
    if (SK > 0 && n != int'(m_ch)) begin
      m_skip = 1;
      m_left = SK;
    end else begin
      m_skip = 0;
      m_left = eff(m_dwell);
    end
    m_ch = 3'(n);
  endtask

  task automatic mstep();
    bit fwd, tl;
    logic [DW-1:0] d;
    logic [2:0] u;
    int n;
    fwd = 0; tl = 0; d = bus.sel_data; u = m_ch;
    if (!cfg_enable) m_busy = 0;
    else if (!m_busy) begin
      if (cfg_mask != 0) begin
        m_mask = cfg_mask;
        m_dwell = cfg_dwell;
        m_busy = 1;
        visit(lowest(cfg_mask));
      end
    end else if (bus.s_axis_tvalid) begin
      m_left--;
      if (m_skip) begin
        if (m_left == 0) begin
          m_skip = 0;
          m_left = eff(m_dwell);
        end
      end else begin
        fwd = 1;
        tl = (m_left == 0) && int'(m_ch) == highest(m_mask);
        if (m_left == 0) begin
          n = next_above(m_mask, int'(m_ch));
          if (n < 0) begin
            m_mask = cfg_mask;
            m_dwell = cfg_dwell;
            n = lowest(cfg_mask);
            if (cfg_mask == 0) m_busy = 0;
          end
          if (m_busy) visit(n);
        end
      end
    end
    if (fwd && o_v && !bus.m_axis_tready) m_ovf = 1;
    else if (ovf_clear) m_ovf = 0;
    if (fwd && (!o_v || bus.m_axis_tready)) begin
      o_v = 1; o_d = d; o_u = u; o_l = tl;
    end else if (bus.m_axis_tready) o_v = 0;
  endtask

  function automatic logic [41:0] expv();
    return {o_v, o_v ? o_d : 32'h0, o_v ? o_u : 3'h0, o_v & o_l, m_ovf, m_busy, m_ch};
  endfunction

  function automatic logic [41:0] obs();
    return {bus.m_axis_tvalid, bus.m_axis_tvalid ? bus.m_axis_tdata : 32'h0,
            bus.m_axis_tvalid ? bus.m_axis_tuser : 3'h0, bus.m_axis_tvalid & bus.m_axis_tlast,
            overflow, busy, bus.sel_cfg};
  endfunction

  function automatic logic [41:0] raw();
    return {bus.m_axis_tvalid, bus.m_axis_tdata, bus.m_axis_tuser, bus.m_axis_tlast,
            overflow, busy, bus.sel_cfg};
  endfunction

  task automatic step();
    @(posedge aclk);
    if (areset) mreset();
    else mstep();
    #1;
  endtask

  task automatic test_reset();
    areset = 1; cfg_enable = 0; cfg_mask = 0; cfg_dwell = 0; ovf_clear = 0;
    bus.sel_data = 0; bus.s_axis_tvalid = 0; bus.m_axis_tready = 0;
    #1;
    mreset();
    step();
    step();
    checks++;
    if (raw() !== 42'h0) begin
      errors++;
      $display("FAIL reset_outputs: got %h want 0", raw());
    end
    areset = 0;
    step();
    checks++;
    if (obs() !== expv()) begin
      errors++;
      $display("FAIL reset_idle: got %h want %h", obs(), expv());
    end
  endtask

  task automatic test_two_chan();
    int tl_cnt;
    tl_cnt = 0;
    cfg_enable = 1; cfg_mask = 8'h05; cfg_dwell = 2; bus.m_axis_tready = 1; bus.s_axis_tvalid = 1;
    for (int i = 0; i < 40; i++) begin
      bus.sel_data = $urandom;
      step();
      tl_cnt += int'(bus.m_axis_tvalid & bus.m_axis_tlast);
      checks++;
      if (obs() !== expv()) begin
        errors++;
        $display("FAIL two_chan cyc %0d: got %h want %h", i, obs(), expv());
      end
    end
    checks++;
    if (tl_cnt < 3) begin
      errors++;
      $display("FAIL two_chan_tlast_count: got %0d want >=3", tl_cnt);
    end
  endtask

  task automatic test_single();
    cfg_mask = 8'h10; cfg_dwell = 3;
    for (int i = 0; i < 40; i++) begin
      bus.sel_data = $urandom;
      step();
      checks++;
      if (obs() !== expv()) begin
        errors++;
        $display("FAIL single cyc %0d: got %h want %h", i, obs(), expv());
      end
    end
  endtask

  task automatic test_backpressure();
    bus.s_axis_tvalid = 0; bus.m_axis_tready = 1;
    step();
    for (int i = 0; i < 6; i++) begin
      bus.s_axis_tvalid = i < 4;
      bus.m_axis_tready = i >= 4;
      bus.sel_data = $urandom;
      step();
      checks++;
      if (obs() !== expv()) begin
        errors++;
        $display("FAIL backpressure cyc %0d: got %h want %h", i, obs(), expv());
      end
    end
    checks++;
    if (overflow !== 1'b1) begin
      errors++;
      $display("FAIL overflow_set: got %b want 1", overflow);
    end
    bus.s_axis_tvalid = 0; ovf_clear = 1;
    step();
    ovf_clear = 0;
    checks++;
    if (overflow !== 1'b0 || obs() !== expv()) begin
      errors++;
      $display("FAIL overflow_clear: got %b/%h want 0/%h", overflow, obs(), expv());
    end
  endtask

  task automatic test_mask_change();
    bit saw7;
    saw7 = 0;
    cfg_mask = 8'h03; cfg_dwell = 1; bus.s_axis_tvalid = 1; bus.m_axis_tready = 1;
    for (int i = 0; i < 36; i++) begin
      if (i == 14) cfg_mask = 8'h80;
      bus.sel_data = $urandom;
      step();
      saw7 |= bus.sel_cfg == 3'd7;
      checks++;
      if (obs() !== expv()) begin
        errors++;
        $display("FAIL mask_change cyc %0d: got %h want %h", i, obs(), expv());
      end
    end
    checks++;
    if (!saw7) begin
      errors++;
      $display("FAIL mask_change_ch7: got sel_cfg %0d want 7", bus.sel_cfg);
    end
  endtask

  task automatic test_disable();
    bus.m_axis_tready = 0; bus.s_axis_tvalid = 1;
    for (int i = 0; i < 2; i++) begin
      bus.sel_data = $urandom;
      step();
    end
    cfg_enable = 0; bus.s_axis_tvalid = 0;
    step();
    checks++;
    if (busy !== 1'b0 || bus.m_axis_tvalid !== 1'b1 || obs() !== expv()) begin
      errors++;
      $display("FAIL disable_hold: got busy %b valid %b (%h) want 0 1 (%h)",
               busy, bus.m_axis_tvalid, obs(), expv());
    end
    bus.s_axis_tvalid = 1;
    for (int i = 0; i < 5; i++) begin
      bus.m_axis_tready = i >= 2;
      bus.sel_data = $urandom;
      step();
      checks++;
      if (obs() !== expv()) begin
        errors++;
        $display("FAIL disable cyc %0d: got %h want %h", i, obs(), expv());
      end
    end
    checks++;
    if (bus.m_axis_tvalid !== 1'b0) begin
      errors++;
      $display("FAIL disable_drained: got tvalid %b want 0", bus.m_axis_tvalid);
    end
  endtask

  task automatic test_dwell0_reset();
    cfg_enable = 1; cfg_mask = 8'h81; cfg_dwell = 0; bus.m_axis_tready = 1; bus.s_axis_tvalid = 1;
    for (int i = 0; i < 24; i++) begin
      bus.sel_data = $urandom;
      step();
      checks++;
      if (obs() !== expv()) begin
        errors++;
        $display("FAIL dwell0 cyc %0d: got %h want %h", i, obs(), expv());
      end
    end
    #2;
    areset = 1;
    #1;
    mreset();
    checks++;
    if (raw() !== 42'h0) begin
      errors++;
      $display("FAIL async_reset: got %h want 0", raw());
    end
    step();
    areset = 0;
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 19) == 0) cfg_enable = ~cfg_enable;
      if ($urandom_range(0, 24) == 0) cfg_mask = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
      if ($urandom_range(0, 24) == 0) cfg_dwell = CW'($urandom_range(0, 3));
      bus.s_axis_tvalid = $urandom_range(0, 9) < 6;
      bus.m_axis_tready = $urandom_range(0, 9) < 7;
      ovf_clear = $urandom_range(0, 19) == 0;
      bus.sel_data = $urandom;
      step();
      checks++;
      if (obs() !== expv()) begin
        errors++;
        $display("FAIL random cyc %0d: got %h want %h", i, obs(), expv());
      end
    end
  endtask

  initial begin
    test_reset();
    test_two_chan();
    test_single();
    test_backpressure();
    test_mask_change();
    test_disable();
    test_dwell0_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
